// File: rtl/sr_pkt_encoder.sv
// Serial write-protocol packet encoder.
// Emits an 8-byte command header (length, signature, address) followed by
// 4 bytes per 32-bit pixel word, LSB first, over a valid/ready byte interface.
// BYTE_GAP inserts idle cycles after every accepted byte to pace slow sinks.
module sr_pkt_encoder #(
  parameter int unsigned BYTE_GAP  = 0,
  parameter logic [15:0] SIGNATURE = 16'hAA55
) (
  input  logic        mem_clk,
  input  logic        reset,

  // Command interface
  input  logic        cmd_start,
  input  logic [15:0] cmd_len,
  input  logic [31:0] cmd_addr,
  output logic        busy,
  output logic        done,

  // Pixel word source
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,

  // Byte sink
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [7:0] GapCnt = 8'(BYTE_GAP);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StAddr,
    StFetch,
    StPix
  } state_e;

  state_e      state_q, state_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  gap_q, gap_d;
  logic        pix_ready_q, pix_ready_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        last_in_group;
  logic        last_word;
  logic        pix_fire;

  assign accept        = tx_valid_q & tx_ready;
  assign last_in_group = (byte_idx_q == 2'd3);
  assign last_word     = (word_cnt_q == (len_q - 16'd1));
  assign pix_fire      = pix_valid & pix_ready_q;

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign pix_ready = pix_ready_q;
  assign busy      = busy_q;
  // Pulses in the same cycle the final byte is handed to the sink.
  assign done      = (state_q == StPix) & accept & last_in_group & last_word;

  // State register with synchronous active-high reset.
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      shift_q     <= 32'h0;
      byte_idx_q  <= 2'd0;
      word_cnt_q  <= 16'h0;
      len_q       <= 16'h0;
      addr_q      <= 32'h0;
      gap_q       <= 8'h00;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      gap_q       <= gap_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: sequencing, byte presentation, pacing and word fetch.
  always_comb begin
    state_d     = state_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    gap_d       = gap_q;
    pix_ready_d = pix_ready_q;
    busy_d      = busy_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_start && (cmd_len != 16'h0)) begin
          len_d      = cmd_len;
          addr_d     = cmd_addr;
          busy_d     = 1'b1;
          state_d    = StHdr;
          byte_idx_d = 2'd0;
          word_cnt_d = 16'h0;
          gap_d      = 8'h00;
          // Byte 0 goes out immediately; the rest of the header waits in shift_q.
          tx_valid_d = 1'b1;
          tx_data_d  = cmd_len[7:0];
          shift_d    = {8'h00, SIGNATURE, cmd_len[15:8]};
        end
      end

      StHdr, StAddr, StPix: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          tx_valid_d = 1'b0;
          gap_d      = GapCnt;
          if (!last_in_group) begin
            if (GapCnt == 8'h00) begin
              tx_valid_d = 1'b1;
              tx_data_d  = shift_q[7:0];
              shift_d    = {8'h00, shift_q[31:8]};
            end
          end else if (state_q == StHdr) begin
            state_d = StAddr;
            shift_d = addr_q;
            if (GapCnt == 8'h00) begin
              tx_valid_d = 1'b1;
              tx_data_d  = addr_q[7:0];
              shift_d    = {8'h00, addr_q[31:8]};
            end
          end else if (state_q == StAddr) begin
            state_d     = StFetch;
            pix_ready_d = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 16'd1;
            if (last_word) begin
              state_d = StIdle;
              busy_d  = 1'b0;
              gap_d   = 8'h00;
            end else begin
              state_d     = StFetch;
              pix_ready_d = 1'b1;
            end
          end
        end else if (!tx_valid_q) begin
          // Pacing gap: present the next byte once the countdown expires.
          if (gap_q <= 8'd1) begin
            gap_d      = 8'h00;
            tx_valid_d = 1'b1;
            tx_data_d  = shift_q[7:0];
            shift_d    = {8'h00, shift_q[31:8]};
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
      end

      StFetch: begin
        // The pacing gap keeps running while we wait for a word.
        if (gap_q != 8'h00) begin
          gap_d = gap_q - 8'd1;
        end
        if (pix_fire) begin
          pix_ready_d = 1'b0;
          state_d     = StPix;
          byte_idx_d  = 2'd0;
          if (gap_q <= 8'd1) begin
            gap_d      = 8'h00;
            tx_valid_d = 1'b1;
            tx_data_d  = pix_data[7:0];
            shift_d    = {8'h00, pix_data[31:8]};
          end else begin
            shift_d = pix_data;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_pkt_encoder.sv
// Scoreboard bench for sr_pkt_encoder: stimulus pushes expected bytes into a
// queue, a monitor pops and compares on every accepted byte.
module tb_sr_pkt_encoder;

  logic        mem_clk = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic [15:0] cmd_len;
  logic [31:0] cmd_addr;
  logic        busy, done;
  logic [31:0] pix_data = 32'h0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  // Second instance with pacing enabled
  logic        g_cmd_start;
  logic [15:0] g_cmd_len;
  logic [31:0] g_cmd_addr;
  logic        g_busy, g_done;
  logic [31:0] g_pix_data;
  logic        g_pix_valid;
  logic        g_pix_ready;
  logic [7:0]  g_tx_data;
  logic        g_tx_valid;
  logic        g_tx_ready;

  always #5 mem_clk = ~mem_clk;

  sr_pkt_encoder #(.BYTE_GAP(0), .SIGNATURE(16'hAA55)) dut (
    .mem_clk   (mem_clk),
    .reset     (reset),
    .cmd_start (cmd_start),
    .cmd_len   (cmd_len),
    .cmd_addr  (cmd_addr),
    .busy      (busy),
    .done      (done),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  sr_pkt_encoder #(.BYTE_GAP(3), .SIGNATURE(16'hAA55)) dut_gap (
    .mem_clk   (mem_clk),
    .reset     (reset),
    .cmd_start (g_cmd_start),
    .cmd_len   (g_cmd_len),
    .cmd_addr  (g_cmd_addr),
    .busy      (g_busy),
    .done      (g_done),
    .pix_data  (g_pix_data),
    .pix_valid (g_pix_valid),
    .pix_ready (g_pix_ready),
    .tx_data   (g_tx_data),
    .tx_valid  (g_tx_valid),
    .tx_ready  (g_tx_ready)
  );

  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pix_q[$];
  logic [31:0] pkt_w[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          acc_cnt = 0;
  int          tx_mode = 0;   // 0: always ready, 1: toggle, 2: random
  bit          pix_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_b(input logic [7:0] b, input bit last);
    exp_t e;
    e.data = b;
    e.last = last;
    exp_q.push_back(e);
  endfunction

  // Reference model: the packet as a flat byte list.
  function automatic void push_pkt(input logic [15:0] len, input logic [31:0] addr);
    push_b(8'(len % 256), 1'b0);
    push_b(8'(len / 256), 1'b0);
    push_b(8'h55, 1'b0);
    push_b(8'hAA, 1'b0);
    for (int i = 0; i < 4; i++) push_b(8'(addr >> (8 * i)), 1'b0);
    for (int w = 0; w < int'(len); w++)
      for (int i = 0; i < 4; i++)
        push_b(8'(pkt_w[w] >> (8 * i)), (w == int'(len) - 1) && (i == 3));
  endfunction

  function automatic void rand_words(input int n);
    pkt_w.delete();
    for (int i = 0; i < n; i++) pkt_w.push_back($urandom);
  endfunction

  // Issue a command at the current time (just after a rising edge).
  task automatic issue(input logic [15:0] len, input logic [31:0] addr, input int npush);
    cmd_start = 1'b1;
    cmd_len   = len;
    cmd_addr  = addr;
    push_pkt(len, addr);
    for (int i = 0; i < npush; i++) pix_q.push_back(pkt_w[i]);
    @(posedge mem_clk); #1;
    cmd_start = 1'b0;
    check("start_latency_valid", {31'b0, tx_valid}, 32'd1);
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 4000; c++) begin
      @(posedge mem_clk); #1;
      if (exp_q.size() == 0 && busy == 1'b0) return;
    end
    check("idle_timeout_bytes_left", exp_q.size(), 32'd0);
    exp_q.delete();
    pix_q.delete();
  endtask

  // Sink-ready and pixel-source drivers.
  initial forever begin
    @(posedge mem_clk); #1;
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    if (pix_q.size() != 0) begin
      pix_data  = pix_q[0];
      pix_valid = !pix_rand || ($urandom_range(0, 1) == 1);
    end else begin
      pix_valid = 1'b0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit stalled;
    stalled = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("valid_held_under_stall", {31'b0, tx_valid}, 32'd1);
        if (tx_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'b0, tx_data}, 32'hFFFF_FFFF);
          end else begin
            check("tx_data", {24'b0, tx_data}, {24'b0, exp_q[0].data});
            check("busy_while_sending", {31'b0, busy}, 32'd1);
            if (tx_ready) begin
              check("done_on_accept", {31'b0, done}, {31'b0, exp_q[0].last});
              void'(exp_q.pop_front());
              acc_cnt++;
            end
          end
        end else begin
          check("no_done_without_byte", {31'b0, done}, 32'd0);
        end
        stalled = tx_valid && !tx_ready;
        if (pix_valid && pix_ready && pix_q.size() != 0) void'(pix_q.pop_front());
      end
    end
  end

  // Paced instance: exactly 3 idle cycles between each accepted byte.
  task automatic run_gap();
    logic [7:0]  eg[12];
    logic [31:0] w, a;
    int          idx, idle;
    w = $urandom;
    a = $urandom;
    eg[0] = 8'h01; eg[1] = 8'h00; eg[2] = 8'h55; eg[3] = 8'hAA;
    for (int i = 0; i < 4; i++) eg[4 + i] = 8'(a >> (8 * i));
    for (int i = 0; i < 4; i++) eg[8 + i] = 8'(w >> (8 * i));
    g_tx_ready  = 1'b1;
    g_pix_valid = 1'b1;
    g_pix_data  = w;
    g_cmd_start = 1'b1;
    g_cmd_len   = 16'd1;
    g_cmd_addr  = a;
    @(posedge mem_clk); #1;
    g_cmd_start = 1'b0;
    idx  = 0;
    idle = 0;
    for (int c = 0; c < 200 && idx < 12; c++) begin
      @(negedge mem_clk);
      if (g_tx_valid) begin
        check("gap_tx_data", {24'b0, g_tx_data}, {24'b0, eg[idx]});
        if (idx > 0) check("gap_idle_cycles", idle, 32'd3);
        check("gap_done", {31'b0, g_done}, {31'b0, idx == 11});
        check("gap_busy", {31'b0, g_busy}, 32'd1);
        idx++;
        idle = 0;
      end else begin
        idle++;
      end
    end
    check("gap_byte_count", idx, 32'd12);
    g_pix_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          base;
    int          len;
    reset = 1'b1;
    cmd_start = 1'b0; cmd_len = 16'h0; cmd_addr = 32'h0;
    g_cmd_start = 1'b0; g_cmd_len = 16'h0; g_cmd_addr = 32'h0;
    g_pix_data = 32'h0; g_pix_valid = 1'b0; g_tx_ready = 1'b0;
    repeat (3) @(posedge mem_clk);
    #1;
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_pix_ready", {31'b0, pix_ready}, 32'd0);
    reset = 1'b0;
    @(posedge mem_clk); #1;

    // Basic packet
    tx_mode = 0; pix_rand = 1'b0;
    pkt_w.delete(); pkt_w.push_back(32'h44332211); pkt_w.push_back(32'h88776655);
    issue(16'd2, 32'h0000_0010, 2);
    wait_idle();

    // Backpressure: ready toggles every cycle
    tx_mode = 1;
    issue(16'd2, 32'h0000_0010, 2);
    wait_idle();

    // Starved source before the third word
    tx_mode = 0;
    rand_words(3);
    base = acc_cnt;
    issue(16'd3, 32'h0123_4567, 2);
    for (int c = 0; c < 200; c++) begin
      @(posedge mem_clk);
      if (acc_cnt - base >= 16) break;
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge mem_clk); #1;
      check("starved_no_valid", {31'b0, tx_valid}, 32'd0);
    end
    pix_q.push_back(pkt_w[2]);
    wait_idle();

    // Zero-length command is ignored
    cmd_start = 1'b1; cmd_len = 16'h0; cmd_addr = $urandom;
    @(posedge mem_clk); #1;
    cmd_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("len0_busy", {31'b0, busy}, 32'd0);
      check("len0_valid", {31'b0, tx_valid}, 32'd0);
      @(posedge mem_clk); #1;
    end

    // cmd_start while busy is ignored
    rand_words(2);
    a = $urandom;
    issue(16'd2, a, 2);
    repeat (3) @(posedge mem_clk);
    #1;
    cmd_start = 1'b1; cmd_len = 16'd5; cmd_addr = ~a;
    @(posedge mem_clk); #1;
    cmd_start = 1'b0;
    wait_idle();
    for (int c = 0; c < 4; c++) begin
      check("after_busy_start_idle", {31'b0, tx_valid}, 32'd0);
      @(posedge mem_clk); #1;
    end

    // cmd_start on the done cycle is ignored, accepted the cycle after
    rand_words(1);
    issue(16'd1, $urandom, 1);
    for (int c = 0; c < 100; c++) begin
      @(negedge mem_clk);
      if (done) break;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    rand_words(1);
    a = $urandom;
    cmd_start = 1'b1; cmd_len = 16'd1; cmd_addr = a;
    push_pkt(16'd1, a);
    pix_q.push_back(pkt_w[0]);
    @(posedge mem_clk); #1;
    check("start_on_done_ignored", {31'b0, busy}, 32'd0);
    @(posedge mem_clk); #1;
    cmd_start = 1'b0;
    check("start_after_done_valid", {31'b0, tx_valid}, 32'd1);
    check("start_after_done_busy", {31'b0, busy}, 32'd1);
    wait_idle();

    // Reset mid-packet after byte 5
    rand_words(3);
    base = acc_cnt;
    issue(16'd3, $urandom, 3);
    for (int c = 0; c < 100; c++) begin
      @(posedge mem_clk);
      if (acc_cnt - base >= 6) break;
    end
    #1;
    reset = 1'b1;
    exp_q.delete();
    pix_q.delete();
    @(posedge mem_clk); #1;
    check("midrst_valid", {31'b0, tx_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    rand_words(1);
    issue(16'd1, $urandom, 1);
    wait_idle();

    // Randomised packets, random backpressure and source stalls
    for (int k = 0; k < 10; k++) begin
      tx_mode  = $urandom_range(0, 2);
      pix_rand = 1'b1;
      len      = $urandom_range(1, 5);
      rand_words(len);
      issue(16'(len), $urandom, len);
      wait_idle();
    end
    pix_rand = 1'b0;
    tx_mode  = 0;

    // Pacing instance
    run_gap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
